// File: rtl/hazard_controller_pkg.sv
// Shared hazard-unit types: FSM states, forwarding select encodings, load decode.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        ERROR   = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_RF         = 2'b00;
    localparam logic [1:0] FWD_WB         = 2'b01;
    localparam logic [1:0] FWD_MEM        = 2'b10;
    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

    // x0 is hardwired to zero, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Datapath <-> hazard controller bundle; master is the datapath, slave the controller.
// Latency: n/a (wiring only).
// Backpressure: n/a; stall/flush outputs are the backpressure into the pipeline.
interface hazard_controller_if;

    logic [4:0]  Rs1D_i;
    logic [4:0]  Rs2D_i;
    logic [4:0]  Rs1E_i;
    logic [4:0]  Rs2E_i;
    logic [4:0]  RdE_i;
    logic [4:0]  RdM_i;
    logic [4:0]  RdW_i;
    logic [1:0]  ResultSrcE_i;
    logic        RegWriteM_i;
    logic        RegWriteW_i;
    logic        PCSrcE_i;
    logic        MemReqM_i;
    logic        MemReadyM_i;

    logic        StallF_o;
    logic        StallD_o;
    logic        StallE_o;
    logic        StallM_o;
    logic        FlushD_o;
    logic        FlushE_o;
    logic        FlushW_o;
    logic [1:0]  ForwardAE_o;
    logic [1:0]  ForwardBE_o;
    logic        MemErr_o;
    logic [31:0] StallCnt_o;
    logic [31:0] FlushCnt_o;

    modport master (
        output Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i,
               ResultSrcE_i, RegWriteM_i, RegWriteW_i, PCSrcE_i,
               MemReqM_i, MemReadyM_i,
        input  StallF_o, StallD_o, StallE_o, StallM_o,
               FlushD_o, FlushE_o, FlushW_o,
               ForwardAE_o, ForwardBE_o, MemErr_o, StallCnt_o, FlushCnt_o
    );

    modport slave (
        input  Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i,
               ResultSrcE_i, RegWriteM_i, RegWriteW_i, PCSrcE_i,
               MemReqM_i, MemReadyM_i,
        output StallF_o, StallD_o, StallE_o, StallM_o,
               FlushD_o, FlushE_o, FlushW_o,
               ForwardAE_o, ForwardBE_o, MemErr_o, StallCnt_o, FlushCnt_o
    );

endinterface

// File: rtl/hazard_controller_forward_sel.sv
// ALU operand forwarding select for one E-stage source register; M result beats W.
// Latency: combinational.
// Backpressure: none.
module forward_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output logic [1:0] fwd_sel
);

    always_comb begin
        fwd_sel = FWD_RF;
        if (reg_write_m && reg_match(rd_m, rs)) begin
            fwd_sel = FWD_MEM;
        end else if (reg_write_w && reg_match(rd_w, rs)) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// 5-stage pipeline hazard unit: stall/flush sequencing, forwarding, memory-wait timeout lockout.
// Latency: stall/flush/forward are combinational; state and MemErr_o update on the clock edge.
// Backpressure: memory wait freezes F..M and bubbles W; HAZARD_PERF_EN builds the perf counters.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_controller_if.slave bus
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    hz_state_t      state_q, state_d;
    logic [CW-1:0]  wait_cnt_q, wait_cnt_d;
    logic           mem_err_q;

    logic           memwait;
    logic           load_use;
    logic           stall_all;
    logic           stall_fd;
    logic           flush_d;
    logic           flush_e;
    logic           flush_w;
    logic [1:0]     fwd_a;
    logic [1:0]     fwd_b;

    forward_sel u_fwd_a (
        .rs          (bus.Rs1E_i),
        .rd_m        (bus.RdM_i),
        .rd_w        (bus.RdW_i),
        .reg_write_m (bus.RegWriteM_i),
        .reg_write_w (bus.RegWriteW_i),
        .fwd_sel     (fwd_a)
    );

    forward_sel u_fwd_b (
        .rs          (bus.Rs2E_i),
        .rd_m        (bus.RdM_i),
        .rd_w        (bus.RdW_i),
        .reg_write_m (bus.RegWriteM_i),
        .reg_write_w (bus.RegWriteW_i),
        .fwd_sel     (fwd_b)
    );

    assign memwait  = bus.MemReqM_i & ~bus.MemReadyM_i;
    assign load_use = (bus.ResultSrcE_i == RESULTSRC_LOAD) &&
                      (reg_match(bus.RdE_i, bus.Rs1D_i) || reg_match(bus.RdE_i, bus.Rs2D_i));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_q | (state_d == ERROR);
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        stall_all  = 1'b0;
        stall_fd   = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        flush_w    = 1'b0;
        case (state_q)
            RUN, MEMWAIT: begin
                if (memwait) begin
                    stall_all = 1'b1;
                    flush_w   = 1'b1;
                    if (state_q == RUN) begin
                        state_d    = MEMWAIT;
                        wait_cnt_d = CW'(1);
                    end else if (wait_cnt_q == CW'(MEM_TIMEOUT)) begin
                        state_d = ERROR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CW'(1);
                    end
                end else begin
                    // On the ready cycle the frozen E instruction is re-evaluated as in RUN.
                    state_d    = RUN;
                    wait_cnt_d = '0;
                    if (bus.PCSrcE_i) begin
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                    end else if (load_use) begin
                        stall_fd = 1'b1;
                        flush_e  = 1'b1;
                    end
                end
            end
            ERROR: begin
                stall_all = 1'b1;
                flush_w   = 1'b1;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // While reset is held every register clears and nothing advances.
    assign bus.StallF_o    = rst_n & (stall_all | stall_fd);
    assign bus.StallD_o    = rst_n & (stall_all | stall_fd);
    assign bus.StallE_o    = rst_n & stall_all;
    assign bus.StallM_o    = rst_n & stall_all;
    assign bus.FlushD_o    = ~rst_n | flush_d;
    assign bus.FlushE_o    = ~rst_n | flush_e;
    assign bus.FlushW_o    = ~rst_n | flush_w;
    assign bus.ForwardAE_o = rst_n ? fwd_a : FWD_RF;
    assign bus.ForwardBE_o = rst_n ? fwd_b : FWD_RF;
    assign bus.MemErr_o    = mem_err_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((stall_all | stall_fd) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if ((flush_d | flush_e) && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign bus.StallCnt_o = stall_cnt_q;
    assign bus.FlushCnt_o = flush_cnt_q;
`else
    assign bus.StallCnt_o = 32'd0;
    assign bus.FlushCnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller (MEM_TIMEOUT=4): forwarding, load-use, memory wait,
// redirect during wait, timeout lockout and reset recovery; perf expectations follow HAZARD_PERF_EN.
module tb_hazard_controller;
    import hazard_pkg::*;

`ifdef HAZARD_PERF_EN
    localparam logic [31:0] EXP_STALL_CNT = 32'd4;
    localparam logic [31:0] EXP_FLUSH_CNT = 32'd1;
`else
    localparam logic [31:0] EXP_STALL_CNT = 32'd0;
    localparam logic [31:0] EXP_FLUSH_CNT = 32'd0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    hazard_controller_if hif ();

    hazard_controller #(.MEM_TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (hif)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        hif.Rs1D_i = 5'd0; hif.Rs2D_i = 5'd0; hif.Rs1E_i = 5'd0; hif.Rs2E_i = 5'd0;
        hif.RdE_i  = 5'd0; hif.RdM_i  = 5'd0; hif.RdW_i  = 5'd0;
        hif.ResultSrcE_i = 2'b00;
        hif.RegWriteM_i = 1'b0; hif.RegWriteW_i = 1'b0;
        hif.PCSrcE_i = 1'b0; hif.MemReqM_i = 1'b0; hif.MemReadyM_i = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    function automatic logic [31:0] stalls();
        return {28'd0, hif.StallF_o, hif.StallD_o, hif.StallE_o, hif.StallM_o};
    endfunction

    function automatic logic [31:0] flushes();
        return {29'd0, hif.FlushD_o, hif.FlushE_o, hif.FlushW_o};
    endfunction

    initial begin
        clear_inputs();
        // Reset: forwarding must read 00 even with a matching M writer present.
        hif.Rs1E_i = 5'd5; hif.RdM_i = 5'd5; hif.RegWriteM_i = 1'b1;
        sample();
        check("rst_stalls",  stalls(),  32'h0);
        check("rst_flushes", flushes(), 32'h7);
        check("rst_fwd_a",   {30'd0, hif.ForwardAE_o}, 32'h0);
        check("rst_memerr",  {31'd0, hif.MemErr_o}, 32'h0);
        check("rst_stallcnt", hif.StallCnt_o, 32'h0);
        next_cycle();
        rst_n = 1'b1;

        // Forwarding priority
        hif.RdW_i = 5'd5; hif.RegWriteW_i = 1'b1;
        hif.Rs2E_i = 5'd0; hif.RdW_i = 5'd5;
        sample();
        check("fwd_a_mem", {30'd0, hif.ForwardAE_o}, 32'h2);
        check("idle_flushes", flushes(), 32'h0);
        check("idle_stalls",  stalls(),  32'h0);
        next_cycle();
        hif.RdM_i = 5'd0;
        sample();
        check("fwd_a_wb", {30'd0, hif.ForwardAE_o}, 32'h1);
        next_cycle();
        hif.Rs2E_i = 5'd0; hif.RdW_i = 5'd0;
        sample();
        check("fwd_b_x0", {30'd0, hif.ForwardBE_o}, 32'h0);
        next_cycle();
        hif.Rs2E_i = 5'd9; hif.RdW_i = 5'd9; hif.RdM_i = 5'd9; hif.RegWriteM_i = 1'b0;
        sample();
        check("fwd_b_wb_nowrm", {30'd0, hif.ForwardBE_o}, 32'h1);
        next_cycle();
        clear_inputs();

        // Load-use bubble
        hif.ResultSrcE_i = RESULTSRC_LOAD; hif.RdE_i = 5'd7; hif.Rs2D_i = 5'd7;
        sample();
        check("lu_stalls",  stalls(),  32'hC);
        check("lu_flushes", flushes(), 32'h2);
        next_cycle();
        clear_inputs();
        sample();
        check("lu_after_stalls", stalls(), 32'h0);
        next_cycle();

        // Memory wait: ready on the fourth request cycle
        hif.MemReqM_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("mw_stalls",  stalls(),  32'hF);
            check("mw_flushes", flushes(), 32'h1);
            next_cycle();
        end
        hif.MemReadyM_i = 1'b1;
        sample();
        check("mw_ready_stalls",  stalls(),  32'h0);
        check("mw_ready_flushes", flushes(), 32'h0);
        next_cycle();
        clear_inputs();
        sample();
        check("perf_stallcnt", hif.StallCnt_o, EXP_STALL_CNT);
        check("perf_flushcnt", hif.FlushCnt_o, EXP_FLUSH_CNT);
        next_cycle();

        // Load-use shadowed by a same-cycle redirect
        hif.ResultSrcE_i = RESULTSRC_LOAD; hif.RdE_i = 5'd7; hif.Rs2D_i = 5'd7; hif.PCSrcE_i = 1'b1;
        sample();
        check("lu_redir_stalls",  stalls(),  32'h0);
        check("lu_redir_flushes", flushes(), 32'h6);
        next_cycle();
        clear_inputs();

        // Zero-wait access
        hif.MemReqM_i = 1'b1; hif.MemReadyM_i = 1'b1;
        sample();
        check("zw_stalls", stalls(), 32'h0);
        next_cycle();
        clear_inputs();
        sample();
        check("zw_next_stalls", stalls(), 32'h0);
        next_cycle();

        // Redirect while waiting is held until ready
        hif.MemReqM_i = 1'b1; hif.PCSrcE_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sample();
            check("mwr_flushes", flushes(), 32'h1);
            check("mwr_stalls",  stalls(),  32'hF);
            next_cycle();
        end
        hif.MemReadyM_i = 1'b1;
        sample();
        check("mwr_ready_flushes", flushes(), 32'h6);
        check("mwr_ready_stalls",  stalls(),  32'h0);
        next_cycle();
        clear_inputs();
        sample();
        check("mwr_after_flushes", flushes(), 32'h0);
        next_cycle();

        // Timeout: one RUN wait cycle plus four MEMWAIT cycles, then ERROR
        hif.MemReqM_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample();
            check("to_memerr_pre", {31'd0, hif.MemErr_o}, 32'h0);
            next_cycle();
        end
        sample();
        check("to_memerr",  {31'd0, hif.MemErr_o}, 32'h1);
        check("to_stalls",  stalls(), 32'hF);
        next_cycle();
        hif.MemReadyM_i = 1'b1;
        sample();
        check("err_sticky", {31'd0, hif.MemErr_o}, 32'h1);
        check("err_stalls", stalls(),  32'hF);
        check("err_flushes", flushes(), 32'h1);
        next_cycle();
        rst_n = 1'b0;
        #1;
        check("err_rst_memerr",  {31'd0, hif.MemErr_o}, 32'h0);
        check("err_rst_stalls",  stalls(),  32'h0);
        check("err_rst_flushes", flushes(), 32'h7);
        next_cycle();
        rst_n = 1'b1;
        clear_inputs();
        sample();
        check("post_rst_stalls",  stalls(), 32'h0);
        check("post_rst_memerr",  {31'd0, hif.MemErr_o}, 32'h0);
        check("post_rst_stallcnt", hif.StallCnt_o, 32'h0);
        check("post_rst_flushcnt", hif.FlushCnt_o, 32'h0);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
